// File: rtl/io_controller.sv
// rtl/io_controller.sv - Mano machine I/O registers, flags and interrupt request
//
// Owns INPR/OUTR, the FGI/FGO flags and IEN. It sequences the keyboard
// load/fgi handshake and the printer valid/ready handshake. It also resolves
// CPU instruction pulses against device events on the shared flags.
//
// Build option: define IO_INTERRUPT_EN to build the IEN register and the
// ION/IOF/int_ack handling. Without it, ien_out and irq_out are constant 0.
//
// Ports:
//   clock, reset_n         system clock; asynchronous active-low reset
//   kbd_data_in/_load_in   keyboard character and level load request
//   fgi_out, inpr_out      input flag (also seen by keyboard) and INPR
//   cpu_inp_in/_out_in     INP / OUT instruction pulses
//   ac_in                  AC(0..WIDTH-1), captured into OUTR on OUT
//   cpu_ion_in/_iof_in     ION / IOF instruction pulses
//   int_ack_in             interrupt cycle taken, clears IEN
//   fgo_out                output flag (1 = printer can take a character)
//   prn_data_out/_valid_out/prn_ready_in  printer stream
//   ien_out, irq_out       interrupt enable and request
module io_controller #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] kbd_data_in,
    input  logic             kbd_load_in,
    output logic             fgi_out,
    output logic [WIDTH-1:0] inpr_out,
    input  logic             cpu_inp_in,
    input  logic             cpu_out_in,
    input  logic [WIDTH-1:0] ac_in,
    input  logic             cpu_ion_in,
    input  logic             cpu_iof_in,
    input  logic             int_ack_in,
    output logic             fgo_out,
    output logic [WIDTH-1:0] prn_data_out,
    output logic             prn_valid_out,
    input  logic             prn_ready_in,
    output logic             ien_out,
    output logic             irq_out
);

    localparam logic [0:0] IN_EMPTY  = 1'b0;
    localparam logic [0:0] IN_FULL   = 1'b1;
    localparam logic [0:0] OUT_IDLE  = 1'b0;
    localparam logic [0:0] OUT_BUSY  = 1'b1;

    logic [0:0]       in_state;
    logic [0:0]       out_state;
    logic [WIDTH-1:0] inpr;
    logic [WIDTH-1:0] outr;
    logic             kbd_arm;
    logic             kbd_accept;
    logic             prn_accept;

    // A load is only taken once per assertion of the level. kbd_arm drops on
    // acceptance and comes back only after the keyboard lowers kbd_load_in.
    // This stops a level held across INP from reloading the same character.
    assign kbd_accept = (in_state == IN_EMPTY) && kbd_load_in && kbd_arm;
    assign prn_accept = (out_state == OUT_BUSY) && prn_ready_in;

    // Input side
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_state <= IN_EMPTY;
            inpr     <= '0;
            kbd_arm  <= 1'b1;
        end else begin
            case (in_state)
                IN_EMPTY: begin
                    // An INP in EMPTY has no effect, so a simultaneous load wins.
                    if (kbd_accept) begin
                        inpr     <= kbd_data_in;
                        in_state <= IN_FULL;
                    end
                end
                IN_FULL: begin
                    if (cpu_inp_in) begin
                        in_state <= IN_EMPTY;
                    end
                end
                default: in_state <= IN_EMPTY;
            endcase

            if (!kbd_load_in) begin
                kbd_arm <= 1'b1;
            end else if (kbd_accept) begin
                kbd_arm <= 1'b0;
            end
        end
    end

    // Output side. OUTR is written only from IDLE, so it stays stable while the
    // printer holds a character. An OUT issued while BUSY is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_state <= OUT_IDLE;
            outr      <= '0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (cpu_out_in) begin
                        outr      <= ac_in;
                        out_state <= OUT_BUSY;
                    end
                end
                OUT_BUSY: begin
                    if (prn_accept) begin
                        out_state <= OUT_IDLE;
                    end
                end
                default: out_state <= OUT_IDLE;
            endcase
        end
    end

    assign fgi_out       = (in_state == IN_FULL);
    assign inpr_out      = inpr;
    assign fgo_out       = (out_state == OUT_IDLE);
    assign prn_valid_out = (out_state == OUT_BUSY);
    assign prn_data_out  = outr;

`ifdef IO_INTERRUPT_EN
    logic ien;

    // Clearing sources take priority over ION. A pulse of int_ack together
    // with ION leaves interrupts disabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ien <= 1'b0;
        end else if (int_ack_in) begin
            ien <= 1'b0;
        end else if (cpu_iof_in) begin
            ien <= 1'b0;
        end else if (cpu_ion_in) begin
            ien <= 1'b1;
        end
    end

    assign ien_out = ien;
    // Decoded from registered state only, so it adds no latency and has no
    // combinational path from any input.
    assign irq_out = ien & (fgi_out | fgo_out);
`else
    logic unused_int_inputs;

    assign unused_int_inputs = cpu_ion_in ^ cpu_iof_in ^ int_ack_in;
    assign ien_out = 1'b0;
    assign irq_out = 1'b0;
`endif

endmodule

// File: tb/tb_io_controller.sv
// tb/tb_io_controller.sv - directed vector bench for io_controller
module tb_io_controller;

`ifdef IO_INTERRUPT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic [7:0] kbd_data_in;
    logic       kbd_load_in;
    logic       fgi_out;
    logic [7:0] inpr_out;
    logic       cpu_inp_in;
    logic       cpu_out_in;
    logic [7:0] ac_in;
    logic       cpu_ion_in;
    logic       cpu_iof_in;
    logic       int_ack_in;
    logic       fgo_out;
    logic [7:0] prn_data_out;
    logic       prn_valid_out;
    logic       prn_ready_in;
    logic       ien_out;
    logic       irq_out;

    int tests;
    int fails;
    int xfers;

    io_controller #(.WIDTH(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .kbd_data_in   (kbd_data_in),
        .kbd_load_in   (kbd_load_in),
        .fgi_out       (fgi_out),
        .inpr_out      (inpr_out),
        .cpu_inp_in    (cpu_inp_in),
        .cpu_out_in    (cpu_out_in),
        .ac_in         (ac_in),
        .cpu_ion_in    (cpu_ion_in),
        .cpu_iof_in    (cpu_iof_in),
        .int_ack_in    (int_ack_in),
        .fgo_out       (fgo_out),
        .prn_data_out  (prn_data_out),
        .prn_valid_out (prn_valid_out),
        .prn_ready_in  (prn_ready_in),
        .ien_out       (ien_out),
        .irq_out       (irq_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Printer transfers, counted at the accepting edge.
    always @(posedge clock) begin
        if (reset_n && prn_valid_out && prn_ready_in) xfers <= xfers + 1;
    end

    typedef struct {
        string      name;
        logic [7:0] kd;
        bit         kl, inp, outp;
        logic [7:0] ac;
        bit         ion, iof, ack, rdy;
        logic [7:0] e_inpr;
        bit         e_fgi, e_fgo;
        logic [7:0] e_pd;
        bit         e_v, e_ien, e_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [7:0] kd, input bit kl,
                       input bit inp, input bit outp, input logic [7:0] ac,
                       input bit ion, input bit iof, input bit ack, input bit rdy,
                       input logic [7:0] e_inpr, input bit e_fgi, input bit e_fgo,
                       input logic [7:0] e_pd, input bit e_v, input bit e_ien,
                       input bit e_irq);
        vec_t v;
        v.name = name; v.kd = kd; v.kl = kl; v.inp = inp; v.outp = outp;
        v.ac = ac; v.ion = ion; v.iof = iof; v.ack = ack; v.rdy = rdy;
        v.e_inpr = e_inpr; v.e_fgi = e_fgi; v.e_fgo = e_fgo; v.e_pd = e_pd;
        v.e_v = e_v; v.e_ien = e_ien; v.e_irq = e_irq;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_inpr, input bit e_fgi,
                             input bit e_fgo, input logic [7:0] e_pd, input bit e_v,
                             input bit e_ien, input bit e_irq);
        check({tag, ".inpr"},  inpr_out,              e_inpr);
        check({tag, ".fgi"},   {7'd0, fgi_out},       {7'd0, e_fgi});
        check({tag, ".fgo"},   {7'd0, fgo_out},       {7'd0, e_fgo});
        check({tag, ".pdata"}, prn_data_out,          e_pd);
        check({tag, ".valid"}, {7'd0, prn_valid_out}, {7'd0, e_v});
        check({tag, ".ien"},   {7'd0, ien_out},       {7'd0, e_ien & INT_EN});
        check({tag, ".irq"},   {7'd0, irq_out},       {7'd0, e_irq & INT_EN});
    endtask

    task automatic idle_inputs();
        kbd_data_in = 8'h00; kbd_load_in = 1'b0; cpu_inp_in = 1'b0;
        cpu_out_in = 1'b0; ac_in = 8'h00; cpu_ion_in = 1'b0;
        cpu_iof_in = 1'b0; int_ack_in = 1'b0; prn_ready_in = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests = 0; fails = 0; xfers = 0;
        idle_inputs();
        reset_n = 1'b0;

        //   name       kd     kl inp out ac    ion iof ack rdy | inpr  fgi fgo pd    v  ien irq
        add("load41",   8'h41, 1, 0, 0, 8'h00, 0, 0, 0, 0,  8'h41, 1, 1, 8'h00, 0, 0, 0);
        add("holdfull", 8'h42, 1, 0, 0, 8'h00, 0, 0, 0, 0,  8'h41, 1, 1, 8'h00, 0, 0, 0);
        add("inp_held", 8'h42, 1, 1, 0, 8'h00, 0, 0, 0, 0,  8'h41, 0, 1, 8'h00, 0, 0, 0);
        add("noreload", 8'h43, 1, 0, 0, 8'h00, 0, 0, 0, 0,  8'h41, 0, 1, 8'h00, 0, 0, 0);
        add("rearm",    8'h43, 0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h41, 0, 1, 8'h00, 0, 0, 0);
        add("load43",   8'h43, 1, 0, 0, 8'h00, 0, 0, 0, 0,  8'h43, 1, 1, 8'h00, 0, 0, 0);
        add("out5a",    8'h00, 0, 0, 1, 8'h5A, 0, 0, 0, 0,  8'h43, 1, 0, 8'h5A, 1, 0, 0);
        add("busy1",    8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h43, 1, 0, 8'h5A, 1, 0, 0);
        add("busy2",    8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0,  8'h43, 1, 0, 8'h5A, 1, 0, 0);
        add("outdrop",  8'h00, 0, 0, 1, 8'hFF, 0, 0, 0, 0,  8'h43, 1, 0, 8'h5A, 1, 0, 0);
        add("accept",   8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1,  8'h43, 1, 1, 8'h5A, 0, 0, 0);
        add("rdyidle",  8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 1,  8'h43, 1, 1, 8'h5A, 0, 0, 0);
        add("ion",      8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0,  8'h43, 1, 1, 8'h5A, 0, 1, 1);
        add("inp_irq",  8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0,  8'h43, 0, 1, 8'h5A, 0, 1, 1);
        add("out11",    8'h00, 0, 0, 1, 8'h11, 0, 0, 0, 0,  8'h43, 0, 0, 8'h11, 1, 1, 0);
        add("inp_load", 8'h0D, 1, 1, 0, 8'h00, 0, 0, 0, 0,  8'h0D, 1, 0, 8'h11, 1, 1, 1);
        add("ack_ion",  8'h00, 0, 0, 0, 8'h00, 1, 0, 1, 0,  8'h0D, 1, 0, 8'h11, 1, 0, 0);
        add("ion2",     8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0,  8'h0D, 1, 0, 8'h11, 1, 1, 1);
        add("iof_ion",  8'h00, 0, 0, 0, 8'h00, 1, 1, 0, 0,  8'h0D, 1, 0, 8'h11, 1, 0, 0);
        add("ion3",     8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 0,  8'h0D, 1, 0, 8'h11, 1, 1, 1);

        step();
        step();
        check_all("reset", 8'h00, 0, 1, 8'h00, 0, 0, 0);
        reset_n = 1'b1;
        step();
        check_all("postrst", 8'h00, 0, 1, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            kbd_data_in  = vecs[i].kd;
            kbd_load_in  = vecs[i].kl;
            cpu_inp_in   = vecs[i].inp;
            cpu_out_in   = vecs[i].outp;
            ac_in        = vecs[i].ac;
            cpu_ion_in   = vecs[i].ion;
            cpu_iof_in   = vecs[i].iof;
            int_ack_in   = vecs[i].ack;
            prn_ready_in = vecs[i].rdy;
            step();
            check_all(vecs[i].name, vecs[i].e_inpr, vecs[i].e_fgi, vecs[i].e_fgo,
                      vecs[i].e_pd, vecs[i].e_v, vecs[i].e_ien, vecs[i].e_irq);
        end

        // Only the 5A character reached the printer; the FF sent while BUSY was dropped.
        check("xfer_count", xfers[7:0], 8'd1);

        // Async reset in BUSY with IEN set: takes effect between edges.
        idle_inputs();
        kbd_data_in = 8'h77;
        kbd_load_in = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 8'h00, 0, 1, 8'h00, 0, 0, 0);
        step();
        reset_n = 1'b1;
        // A load held through reset is taken on the first edge after release.
        step();
        check_all("held_load", 8'h77, 1, 1, 8'h00, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
